// File: rtl/id_imm_pipe.sv
// Decode-stage immediate extractor: decodes the RV32I/RV64I/Zicsr immediate at accept time
// and presents it through a registered valid/ready output backed by a one-entry skid buffer.
module id_imm_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4,
    output logic            out_illegal
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            illegal;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d, dec;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept, pop;
    logic [XLEN-1:0] sext_v, imm_v;

    assign in_ready = ~skid_valid_q & ~rst;
    assign accept   = in_valid & in_ready;
    assign pop      = main_valid_q & out_ready;

    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        dec.pc4 = in_pc + XLEN'(4);
        // Every signed format extends from inst[31]; start from all-sign bits and overlay the field.
        sext_v  = {XLEN{in_inst[31]}};
        imm_v   = '0;
        if (in_inst[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (in_inst[6:2])
                5'b00000, 5'b00100, 5'b11001: begin
                    imm_v        = sext_v;
                    imm_v[11:0]  = in_inst[31:20];
                    dec.imm_type = T_I;
                end
                5'b00110: begin
                    if (XLEN == 64) begin
                        imm_v        = sext_v;
                        imm_v[11:0]  = in_inst[31:20];
                        dec.imm_type = T_I;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                5'b01000: begin
                    imm_v        = sext_v;
                    imm_v[11:0]  = {in_inst[31:25], in_inst[11:7]};
                    dec.imm_type = T_S;
                end
                5'b11000: begin
                    imm_v        = sext_v;
                    imm_v[12:0]  = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                    dec.imm_type = T_B;
                end
                5'b01101, 5'b00101: begin
                    imm_v        = sext_v;
                    imm_v[31:0]  = {in_inst[31:12], 12'b0};
                    dec.imm_type = T_U;
                end
                5'b11011: begin
                    imm_v        = sext_v;
                    imm_v[20:0]  = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                    dec.imm_type = T_J;
                end
                5'b11100: begin
                    if (in_inst[14]) begin
                        imm_v[4:0]   = in_inst[19:15];
                        dec.imm_type = T_Z;
                    end
                end
                5'b01100, 5'b00011: ;
                5'b01110: dec.illegal = (XLEN != 64);
                default:  dec.illegal = 1'b1;
            endcase
        end
        dec.imm = imm_v;
    end

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            // in_ready is low whenever skid holds data, so a refill from skid never races an accept.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid    = main_valid_q;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.imm_type;
    assign out_pc       = main_q.pc;
    assign out_pc4      = main_q.pc4;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_id_imm_pipe.sv
// Directed bench for id_imm_pipe: XLEN=32 and XLEN=64 instances driven from shared stimulus.
module tb_id_imm_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] inst;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32, opc32, opc4_32;
    logic [2:0]  typ32;
    logic        rdy64, ov64, ill64;
    logic [63:0] imm64, opc64, opc4_64;
    logic [2:0]  typ64;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    always #5 clk = ~clk;

    id_imm_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(inst), .in_pc(pc32), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_imm_type(typ32), .out_pc(opc32), .out_pc4(opc4_32),
        .out_illegal(ill32)
    );

    id_imm_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(inst), .in_pc(pc64), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_imm_type(typ64), .out_pc(opc64), .out_pc4(opc4_64),
        .out_illegal(ill64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        step_no++;
        $display("step %0d: in_valid=%0b inst=%08h pc=%08h flush=%0b out_ready=%0b -> out_valid=%0b imm=%08h type=%0d in_ready=%0b",
                 step_no, in_valid, inst, pc32, flush, out_ready, ov32, imm32, typ32, rdy32);
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        inst     = i;
        pc32     = p;
        pc64     = {32'h0, p};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = 32'h0; pc32 = 32'h0; pc64 = 64'h0;
        step(); step();
        check("rst_out_valid", ov32, 0);
        check("rst_in_ready", rdy32, 0);
        check("rst_imm", imm32, 0);
        check("rst_pc4", opc4_32, 0);
        rst = 1'b0; #1;
        check("post_rst_in_ready", rdy32, 1);

        // addi x1,x0,-1
        out_ready = 1'b1;
        push(32'hFFF00093, 32'h100); step();
        check("i_valid", ov32, 1);
        check("i_imm", imm32, 32'hFFFFFFFF);
        check("i_type", typ32, 1);
        check("i_pc", opc32, 32'h100);
        check("i_pc4", opc4_32, 32'h104);
        check("i_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);

        push(32'hFE000EE3, 32'h104); step();
        check("b_imm", imm32, 32'hFFFFFFFC);
        check("b_type", typ32, 3);
        check("b_illegal", ill32, 0);

        push(32'hFE20AC23, 32'h108); step();
        check("s_imm", imm32, 32'hFFFFFFF8);
        check("s_type", typ32, 2);

        push(32'h123450B7, 32'h10C); step();
        check("u_imm", imm32, 32'h12345000);
        check("u_type", typ32, 4);

        push(32'h008000EF, 32'h110); step();
        check("j_imm", imm32, 32'h8);
        check("j_type", typ32, 5);

        push(32'h800000B7, 32'h114); step();
        check("u32_imm", imm32, 32'h80000000);
        check("u64_imm", imm64, 64'hFFFFFFFF80000000);
        check("u64_type", typ64, 4);

        push(32'h300FD073, 32'h118); step();
        check("z64_imm", imm64, 64'h1F);
        check("z64_type", typ64, 6);
        check("z64_illegal", ill64, 0);

        push(32'h0000001B, 32'h11C); step();
        check("opimm32_x32_illegal", ill32, 1);
        check("opimm32_x32_type", typ32, 0);
        check("opimm32_x64_illegal", ill64, 0);
        check("opimm32_x64_type", typ64, 1);

        push(32'h00000033, 32'h120); step();
        check("op_type", typ32, 0);
        check("op_illegal", ill32, 0);

        push(32'h00000001, 32'hFFFFFFFC); step();
        check("low2_illegal", ill32, 1);
        check("low2_imm", imm32, 0);
        check("pc4_wrap", opc4_32, 0);
        check("pc4_x64_nowrap", opc4_64, 64'h100000000);

        in_valid = 1'b0; step();
        check("drain_valid", ov32, 0);

        // Backpressure: A to main, B to skid, C held off.
        out_ready = 1'b0;
        push(32'h00100093, 32'h200); step();
        check("bp_a_valid", ov32, 1);
        check("bp_a_pc", opc32, 32'h200);
        check("bp_a_ready", rdy32, 1);
        push(32'h00200093, 32'h204); step();
        check("bp_b_ready", rdy32, 0);
        check("bp_b_hold_pc", opc32, 32'h200);
        push(32'h00300093, 32'h208); step();
        check("bp_c_ready", rdy32, 0);
        check("bp_c_hold_imm", imm32, 1);
        out_ready = 1'b1; step();
        check("bp_out_b_imm", imm32, 2);
        check("bp_out_b_pc", opc32, 32'h204);
        check("bp_ready_back", rdy32, 1);
        step();
        check("bp_out_c_imm", imm32, 3);
        check("bp_out_c_valid", ov32, 1);
        in_valid = 1'b0; step();
        check("bp_empty", ov32, 0);

        // Flush with main and skid full and an entry offered.
        out_ready = 1'b0;
        push(32'h00400093, 32'h300); step();
        push(32'h00500093, 32'h304); step();
        check("fl_skid_full", rdy32, 0);
        push(32'h00600093, 32'h308); flush = 1'b1; step();
        check("fl_valid", ov32, 0);
        check("fl_ready", rdy32, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        check("fl_no_leftover", ov32, 0);
        push(32'h00700093, 32'h400); flush = 1'b1; step();
        check("fl_drop_accept", ov32, 0);
        flush = 1'b0; in_valid = 1'b0; step();
        check("fl_drop_stays", ov32, 0);

        // Reset during a stall.
        out_ready = 1'b0;
        push(32'h00800093, 32'h500); step();
        push(32'h00900093, 32'h504); step();
        in_valid = 1'b0; rst = 1'b1; step();
        check("rst_stall_valid", ov32, 0);
        check("rst_stall_ready", rdy32, 0);
        check("rst_stall_imm", imm32, 0);
        check("rst_stall_pc", opc32, 0);
        rst = 1'b0; #1;
        check("rst_stall_ready_back", rdy32, 1);
        out_ready = 1'b1; step();
        check("rst_stall_empty", ov32, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
